// File: rtl/codec_i2c_arbiter.sv
//------------------------------------------------------------------------------
// codec_i2c_arbiter: codec init sequencer + 2-port round-robin arbiter for one
// i2c_com engine; optional WAIT_END watchdog under `ARB_TIMEOUT_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module codec_i2c_arbiter #(
  parameter int         DIV       = 1249,
  parameter int         MAX_RETRY = 3,
  parameter logic [7:0] DEV_ADDR  = 8'h34
`ifdef ARB_TIMEOUT_EN
  , parameter int       TMO_CYC   = 2000000
`endif
) (
  input  logic        clock_50m,
  input  logic        reset_n,
  output logic        clock_i2c,
  output logic [23:0] i2c_data,
  output logic        start,
  input  logic        tr_end,
  input  logic        ack,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic        init_done,
  output logic        cfg_err,
  output logic        busy
);

  localparam int c_GUARD = 2 * (DIV + 1);
  localparam int c_DIV_W = $clog2(DIV + 2);
  localparam int c_GRD_W = $clog2(c_GUARD + 1);
  localparam int c_RTY_W = $clog2(MAX_RETRY + 2);

  localparam logic [2:0] c_IDLE     = 3'd0;
  localparam logic [2:0] c_ISSUE    = 3'd1;
  localparam logic [2:0] c_WAIT_END = 3'd2;
  localparam logic [2:0] c_CHECK    = 3'd3;
  localparam logic [2:0] c_WAIT_CLR = 3'd4;
  localparam logic [2:0] c_FINISH   = 3'd5;

  logic [c_DIV_W-1:0] div_cnt_q;
  logic               clk_i2c_q;
  logic               tr_m_q, tr_s_q, ack_m_q, ack_s_q;
  logic [2:0]         state_q, state_d;
  logic [3:0]         idx_q;
  logic [15:0]        word_q;
  logic [23:0]        i2c_data_q;
  logic               start_q, busy_q, init_done_q, cfg_err_q;
  logic               done0_q, done1_q, err0_q, err1_q;
  logic               gnt_q, rr_q, retry_q, fail_q;
  logic [c_RTY_W-1:0] rty_cnt_q;
  logic [c_GRD_W-1:0] grd_cnt_q;
  logic               w_grant, w_guard_done, w_tmo_hit, w_nack;

  function automatic logic [15:0] init_word(input logic [3:0] i);
    case (i)
      4'd0:    init_word = 16'h001f;
      4'd1:    init_word = 16'h021f;
      4'd2:    init_word = 16'h0479;
      4'd3:    init_word = 16'h0679;
      4'd4:    init_word = 16'h08f8;
      4'd5:    init_word = 16'h0a00;
      4'd6:    init_word = 16'h0c00;
      4'd7:    init_word = 16'h0e01;
      4'd8:    init_word = 16'h1006;
      4'd9:    init_word = 16'h1201;
      default: init_word = 16'h0000;
    endcase
  endfunction

  always_ff @(posedge clock_50m or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q <= '0;
      clk_i2c_q <= 1'b0;
      tr_m_q    <= 1'b0;
      tr_s_q    <= 1'b0;
      ack_m_q   <= 1'b0;
      ack_s_q   <= 1'b0;
    end else begin
      if (div_cnt_q == c_DIV_W'(DIV)) begin
        div_cnt_q <= '0;
        clk_i2c_q <= ~clk_i2c_q;
      end else begin
        div_cnt_q <= div_cnt_q + 1'b1;
      end
      tr_m_q  <= tr_end;
      tr_s_q  <= tr_m_q;
      ack_m_q <= ack;
      ack_s_q <= ack_m_q;
    end
  end

  // Tie goes to rr_q; otherwise the lone requester (req0 low => port 1).
  assign w_grant      = (req0 && req1) ? rr_q : !req0;
  assign w_guard_done = !tr_s_q && (grd_cnt_q == c_GRD_W'(c_GUARD - 1));

`ifdef ARB_TIMEOUT_EN
  logic [31:0] tmo_cnt_q;
  logic        tmo_q;

  assign w_tmo_hit = (state_q == c_WAIT_END) && !tr_s_q && (tmo_cnt_q == 32'(TMO_CYC - 1));
  assign w_nack    = ack_s_q | tmo_q;

  always_ff @(posedge clock_50m or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      if (state_q == c_ISSUE) tmo_cnt_q <= '0;
      else if (state_q == c_WAIT_END && !tr_s_q && !w_tmo_hit) tmo_cnt_q <= tmo_cnt_q + 32'd1;
      if (w_tmo_hit) tmo_q <= 1'b1;
      else if (state_q == c_CHECK) tmo_q <= 1'b0;
    end
  end
`else
  assign w_tmo_hit = 1'b0;
  assign w_nack    = ack_s_q;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:     if (!init_done_q || req0 || req1) state_d = c_ISSUE;
      c_ISSUE:    state_d = c_WAIT_END;
      c_WAIT_END: if (tr_s_q || w_tmo_hit) state_d = c_CHECK;
      c_CHECK:    state_d = c_WAIT_CLR;
      c_WAIT_CLR: if (w_guard_done) state_d = retry_q ? c_ISSUE : c_FINISH;
      c_FINISH:   state_d = c_IDLE;
      default:    state_d = c_IDLE;
    endcase
  end

  always_ff @(posedge clock_50m or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= c_IDLE;
      idx_q       <= '0;
      word_q      <= '0;
      i2c_data_q  <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      init_done_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      gnt_q       <= 1'b0;
      rr_q        <= 1'b0;
      retry_q     <= 1'b0;
      fail_q      <= 1'b0;
      rty_cnt_q   <= '0;
      grd_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      if (state_q == c_WAIT_CLR && !tr_s_q && !w_guard_done) grd_cnt_q <= grd_cnt_q + 1'b1;
      else grd_cnt_q <= '0;
      case (state_q)
        c_IDLE: begin
          if (!init_done_q) begin
            word_q <= init_word(idx_q);
          end else if (req0 || req1) begin
            gnt_q  <= w_grant;
            word_q <= w_grant ? wdata1 : wdata0;
          end
        end
        c_ISSUE: begin
          i2c_data_q <= {DEV_ADDR, word_q};
          start_q    <= 1'b1;
          busy_q     <= 1'b1;
        end
        c_WAIT_END: if (tr_s_q || w_tmo_hit) start_q <= 1'b0;
        c_CHECK: begin
          if (!w_nack) begin
            fail_q  <= 1'b0;
            retry_q <= 1'b0;
          end else if (rty_cnt_q < c_RTY_W'(MAX_RETRY)) begin
            rty_cnt_q <= rty_cnt_q + 1'b1;
            retry_q   <= 1'b1;
            fail_q    <= 1'b0;
          end else begin
            fail_q  <= 1'b1;
            retry_q <= 1'b0;
          end
        end
        c_FINISH: begin
          if (!init_done_q) begin
            if (fail_q) cfg_err_q <= 1'b1;
            idx_q <= idx_q + 4'd1;
            if (idx_q == 4'd9) init_done_q <= 1'b1;
          end else begin
            done0_q <= !gnt_q;
            done1_q <= gnt_q;
            err0_q  <= !gnt_q && fail_q;
            err1_q  <= gnt_q && fail_q;
            rr_q    <= ~gnt_q;
          end
          busy_q    <= 1'b0;
          rty_cnt_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign clock_i2c = clk_i2c_q;
  assign i2c_data  = i2c_data_q;
  assign start     = start_q;
  assign busy      = busy_q;
  assign init_done = init_done_q;
  assign cfg_err   = cfg_err_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign err0      = err0_q;
  assign err1      = err1_q;

endmodule

`default_nettype wire

// File: tb/tb_codec_i2c_arbiter.sv
//------------------------------------------------------------------------------
// tb_codec_i2c_arbiter: scoreboard bench with an i2c_com engine model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_codec_i2c_arbiter;

  localparam int TB_DIV   = 3;
  localparam int TB_GUARD = 2 * (TB_DIV + 1);
  localparam int TB_TMO   = 1000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clock_i2c;
  logic [23:0] i2c_data;
  logic        start;
  logic        tr_end;
  logic        ack;
  logic        req0, req1;
  logic [15:0] wdata0, wdata1;
  logic        done0, done1, err0, err1;
  logic        init_done, cfg_err, busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [23:0] exp_tx[$];
  logic [1:0]  exp_done[$];   // {port, err}
  logic [15:0] init_tbl[0:9];

  logic [23:0] nack_word;
  int          nack_left;
  bit          mute;

  codec_i2c_arbiter #(
    .DIV(TB_DIV), .MAX_RETRY(3), .DEV_ADDR(8'h34)
`ifdef ARB_TIMEOUT_EN
    , .TMO_CYC(TB_TMO)
`endif
  ) dut (
    .clock_50m(clk), .reset_n(reset_n), .clock_i2c(clock_i2c), .i2c_data(i2c_data),
    .start(start), .tr_end(tr_end), .ack(ack), .req0(req0), .req1(req1),
    .wdata0(wdata0), .wdata1(wdata1), .done0(done0), .done1(done1),
    .err0(err0), .err1(err1), .init_done(init_done), .cfg_err(cfg_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Engine model: ACK/NACK after a short delay, hold tr_end until start drops.
  int   eng_phase, eng_dly;
  logic eng_prev, eng_ack;
  initial begin
    tr_end = 1'b0; ack = 1'b0; eng_phase = 0; eng_dly = 0; eng_prev = 1'b0; eng_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        tr_end = 1'b0; ack = 1'b0; eng_phase = 0; eng_prev = 1'b0;
      end else begin
        case (eng_phase)
          0: if (start && !eng_prev && !mute) begin
               eng_ack = (i2c_data == nack_word) && (nack_left > 0);
               if (eng_ack) nack_left--;
               eng_dly = 5; eng_phase = 1;
             end
          1: if (eng_dly == 0) begin ack = eng_ack; tr_end = 1'b1; eng_phase = 2; end
             else eng_dly--;
          2: if (!start) begin eng_dly = 3; eng_phase = 3; end
          default: if (eng_dly == 0) begin tr_end = 1'b0; eng_phase = 0; end
                   else eng_dly--;
        endcase
        eng_prev = start;
      end
    end
  end

  // Monitor: transactions, handshake timing, clock divider and done pulses.
  logic       mon_prev = 1'b0, trend_prev = 1'b0, clki_prev = 1'b0;
  int         last_fall = -1, last_tog = -1, rise_cyc = 0;
  logic [1:0] de;
  always @(negedge clk) begin
    if (!reset_n) begin
      mon_prev = 1'b0; trend_prev = 1'b0; clki_prev = 1'b0; last_fall = -1; last_tog = -1;
    end else begin
      if (start && !mon_prev) begin
        if (exp_tx.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_tx: got %06h, expected none", i2c_data);
        end else begin
          chk("tx_data", {8'h0, i2c_data}, {8'h0, exp_tx.pop_front()});
        end
        if (last_fall >= 0) chk("guard_gap_ok", 32'(cyc - last_fall >= TB_GUARD), 1);
        rise_cyc = cyc;
      end
`ifdef ARB_TIMEOUT_EN
      if (!start && mon_prev && mute) chk("tmo_start_len", cyc - rise_cyc, TB_TMO);
`endif
      if (!tr_end && trend_prev) last_fall = cyc;
      if (clock_i2c != clki_prev) begin
        if (last_tog >= 0) chk("i2c_half_period", cyc - last_tog, TB_DIV + 1);
        last_tog = cyc;
      end
      if (done0 || done1) begin
        if (exp_done.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=%b%b, expected none", done1, done0);
        end else begin
          de = exp_done.pop_front();
          chk("done_port", {30'h0, done1, done0}, de[1] ? 32'd2 : 32'd1);
          chk("done_err", done1 ? err1 : err0, de[0]);
        end
      end
      mon_prev = start; trend_prev = tr_end; clki_prev = clock_i2c;
    end
  end

  task automatic push_init(input int nack_idx, input int attempts);
    for (int i = 0; i < 10; i++) begin
      if (i == nack_idx) for (int k = 1; k < attempts; k++) exp_tx.push_back({8'h34, init_tbl[i]});
      exp_tx.push_back({8'h34, init_tbl[i]});
    end
  endtask

  // Runs until the scoreboard drains and the DUT is idle; requesters drop req on done.
  task automatic wait_settle(input string name, input int budget);
    int n = 0;
    forever begin
      @(negedge clk);
      if (done0) req0 = 1'b0;
      if (done1) req1 = 1'b0;
      if (exp_tx.size() == 0 && exp_done.size() == 0 && !busy) break;
      if (++n >= budget) begin
        checks++; errors++;
        $display("FAIL %s_timeout: got %0d tx / %0d done pending, expected 0", name,
                 exp_tx.size(), exp_done.size());
        exp_tx.delete(); exp_done.delete();
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    init_tbl = '{16'h001f, 16'h021f, 16'h0479, 16'h0679, 16'h08f8,
                 16'h0a00, 16'h0c00, 16'h0e01, 16'h1006, 16'h1201};
    reset_n = 1'b0; req0 = 1'b0; req1 = 1'b0; wdata0 = '0; wdata1 = '0;
    mute = 1'b0; nack_left = 0; nack_word = '0;
    repeat (3) @(negedge clk);
    chk("rst_start", start, 0);
    chk("rst_i2c_data", i2c_data, 0);
    chk("rst_clock_i2c", clock_i2c, 0);
    chk("rst_flags", {busy, init_done, cfg_err, done0, done1, err0, err1}, 0);

    // Reset asserted while entry 2 waits for tr_end; init must restart at entry 0.
    push_init(-1, 1);
    reset_n = 1'b1;
    for (int n = 0; n < 2000 && !(start && i2c_data == 24'h340479); n++) @(negedge clk);
    chk("reached_entry2", {8'h0, i2c_data}, 32'h340479);
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_start", start, 0);
    chk("async_rst_data", i2c_data, 0);
    chk("async_rst_flags", {clock_i2c, busy, init_done, cfg_err}, 0);
    exp_tx.delete();
    repeat (2) @(negedge clk);
    push_init(-1, 1);
    reset_n = 1'b1;
    wait_settle("init_ack", 3000);
    chk("init_done_ack", init_done, 1);
    chk("cfg_err_ack", cfg_err, 0);

    // Entry 4 NACKs all 4 attempts; req1 held from reset must wait for init_done.
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    nack_word = 24'h3408f8; nack_left = 4;
    push_init(4, 4);
    wdata1 = 16'h1234; req1 = 1'b1;
    exp_tx.push_back(24'h341234); exp_done.push_back(2'b10);
    reset_n = 1'b1;
    wait_settle("init_nack", 4000);
    chk("cfg_err_nack", cfg_err, 1);
    chk("init_done_nack", init_done, 1);
    chk("nack_consumed", nack_left, 0);

    // Simultaneous requests: pointer points at port 0 after port 1 was served.
    wdata0 = 16'h0a06; wdata1 = 16'h0c10; req0 = 1'b1; req1 = 1'b1;
    exp_tx.push_back(24'h340a06); exp_tx.push_back(24'h340c10);
    exp_done.push_back(2'b00); exp_done.push_back(2'b10);
    wait_settle("tie", 2000);

    // Lone req1 against the pointer, NACK twice then ACK.
    nack_word = 24'h340e05; nack_left = 2;
    wdata1 = 16'h0e05; req1 = 1'b1;
    repeat (3) exp_tx.push_back(24'h340e05);
    exp_done.push_back(2'b10);
    wait_settle("retry_ok", 2000);
    chk("retry_consumed", nack_left, 0);

    // Lone req0 NACKed on every attempt: done0 with err0.
    nack_word = 24'h340812; nack_left = 4;
    wdata0 = 16'h0812; req0 = 1'b1;
    repeat (4) exp_tx.push_back(24'h340812);
    exp_done.push_back(2'b01);
    wait_settle("retry_fail", 2000);

`ifdef ARB_TIMEOUT_EN
    mute = 1'b1;
    wdata0 = 16'h0123; req0 = 1'b1;
    repeat (4) exp_tx.push_back(24'h340123);
    exp_done.push_back(2'b01);
    wait_settle("watchdog", 8000);
    mute = 1'b0;
`endif

    chk("final_busy", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
